regfile_2r1w_param: RTL
=======================

// Module: regfile_2r1w_param
// PURPOSE
//  Parametrised 2-read/1-write general-purpose register file for the MIPS datapath (ID-stage reads, WB-stage write).
//  Adds over the previous register file: configurable width/depth, hardwired-zero register, write-to-read bypass,
//  and a sequential reset-clear engine with Busy handshake. Replaces initial-block preloading.
//  Tri-state outputs are no longer used.
// PARAMETERS
//  DATA_WIDTH      32  bits per register
//  ADDR_WIDTH      5   address bits; DEPTH = 2**ADDR_WIDTH registers
//  ZERO_REG        1   1: register 0 reads 0, writes to it discarded; 0: register 0 is ordinary
//  BYPASS          1   1: same-cycle write data forwarded to matching read port; 0: no forwarding
//  CLEAR_ON_RESET  1   1: reset zeroes all registers via clear sequence; 0: reset does not touch contents
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous reset, active-high
//  ReadAddress1  in   ADDR_WIDTH  read port 1 address
//  ReadAddress2  in   ADDR_WIDTH  read port 2 address
//  WriteAddress  in   ADDR_WIDTH  write address
//  WriteData     in   DATA_WIDTH  write data
//  WriteEn       in   1           write enable, sampled at rising clk
//  ReadData1     out  DATA_WIDTH  read port 1 data (combinational)
//  ReadData2     out  DATA_WIDTH  read port 2 data (combinational)
//  Busy          out  1           1 while clear sequence runs; writes dropped, reads return 0
//  WriteDropped  out  1           registered 1-cycle pulse: a WriteEn was discarded because Busy was 1
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain. Reset is synchronous: acts only on a rising clk edge with rst=1.
//  FSM states: CLEAR, READY.
//  - rst=1 at edge, CLEAR_ON_RESET=1: state<=CLEAR, ClearPtr<=0, Busy=1, WriteDropped=0.
//  - rst=1 at edge, CLEAR_ON_RESET=0: state<=READY, Busy=0, WriteDropped=0, contents unchanged.
//  - CLEAR: each edge with rst=0 writes 0 to regs[ClearPtr] and increments ClearPtr.
//    The edge that clears DEPTH-1 moves to READY.
//    Busy deasserts exactly DEPTH edges after the first rst=0 edge (32 for defaults).
//  - rst re-asserted mid-CLEAR restarts the sequence: ClearPtr<=0, Busy stays 1.
//  - READY: stays until rst.
//  Writes
//  - READY and WriteEn=1 at edge: regs[WriteAddress]<=WriteData.
//    Exception: WriteAddress=0 with ZERO_REG=1 is discarded silently (no WriteDropped pulse).
//  - Busy=1 and WriteEn=1 (rst=0): write discarded; WriteDropped=1 for the next cycle.
//  - WriteDropped is 0 in all other cycles.
//  Reads
//  - Reads are asynchronous, 0-cycle latency. Priority per port, highest first:
//    (a) Busy=1 -> 0
//    (b) ZERO_REG=1 and addr=0 -> 0
//    (c) BYPASS=1 and WriteEn=1 and WriteAddress=addr -> WriteData
//    (d) otherwise regs[addr]
//  - With BYPASS=0, a read of an address being written returns the old value until after the edge.
//  - Both ports may read the same address; both may bypass at once.
//  Widths and coverage
//  - No arithmetic besides ClearPtr, which is ADDR_WIDTH bits.
//  - Termination is on ClearPtr==DEPTH-1, not on wrap.
//  - All outputs are defined (never X/Z) after the first reset edge.
// TESTING
//  T1 Clear sequence: preload regs (CLEAR_ON_RESET=1), rst 1 edge, then release.
//     -> Busy=1 for 32 edges then 0; all 32 regs read 0.
//  T2 Zero register: write 0xDEADBEEF to r0 -> ReadData1(addr 0)=0, no WriteDropped.
//     With ZERO_REG=0, the same write reads back 0xDEADBEEF.
//  T3 Bypass: WriteEn=1, WriteAddress=5, WriteData=0x12345678, ReadAddress1=ReadAddress2=5
//     in the same cycle -> both ports read 0x12345678 before the edge.
//     With BYPASS=0, both read the old value.
//  T4 Write during Busy: WriteEn=1, addr 3, data 0xA5A5A5A5 at clear cycle 10.
//     -> WriteDropped=1 for 1 cycle; after Busy=0, r3 reads 0.
//  T5 Reset mid-clear: rst at clear cycle 20 -> ClearPtr restarts.
//     Busy stays 1 for a further 32 edges after rst release.
//  T6 Back-to-back: writes r1=5, r2=15, r3=2 on consecutive cycles, read r1/r2 then r3 on both ports.
//     -> 5/15/2 exactly as written; random write/read traffic matches the scoreboard model.

Source files
------------

// File: rtl/regfile_2r1w_param_if.sv
// Register-file port bundle: two read ports, one write port and clear-status flags.
interface regfile_2r1w_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadAddress1;
  logic [ADDR_WIDTH-1:0] ReadAddress2;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  WriteEn;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic                  Busy;
  logic                  WriteDropped;

  modport master (
    output ReadAddress1, ReadAddress2, WriteAddress, WriteData, WriteEn,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  ReadAddress1, ReadAddress2, WriteAddress, WriteData, WriteEn,
    output ReadData1, ReadData2, Busy, WriteDropped
  );
endinterface

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2R/1W register file with hardwired zero, write bypass and reset clear engine.
//   state | meaning
//   CLEAR | zeroing regs[clr_ptr] one per edge; writes dropped, reads return 0
//   READY | normal read/write operation
module regfile_2r1w_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_2r1w_param_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    dropped_q, dropped_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    dropped_d = 1'b0;
    regs_d    = regs_q;
    if (rst) begin
      if (CLEAR_ON_RESET != 0) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end else begin
        state_d = READY;
      end
    end else if (state_q == CLEAR) begin
      regs_d[clr_ptr_q] = '0;
      clr_ptr_d         = clr_ptr_q + ADDR_WIDTH'(1);
      dropped_d         = bus.WriteEn;
      if (clr_ptr_q == LAST_PTR) state_d = READY;
    end else if (bus.WriteEn && !((ZERO_REG != 0) && (bus.WriteAddress == '0))) begin
      regs_d[bus.WriteAddress] = bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    dropped_q <= dropped_d;
    regs_q    <= regs_d;
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  busy,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  wen,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (busy)                                 return '0;
    else if ((ZERO_REG != 0) && addr == '0)   return '0;
    else if ((BYPASS != 0) && wen && waddr == addr) return wdata;
    else                                      return stored;
  endfunction

  logic busy;
  assign busy             = (state_q == CLEAR);
  assign bus.Busy         = busy;
  assign bus.WriteDropped = dropped_q;

  always_comb begin
    bus.ReadData1 = read_port(busy, bus.ReadAddress1, bus.WriteEn, bus.WriteAddress,
                              bus.WriteData, regs_q[bus.ReadAddress1]);
    bus.ReadData2 = read_port(busy, bus.ReadAddress2, bus.WriteEn, bus.WriteAddress,
                              bus.WriteData, regs_q[bus.ReadAddress2]);
  end
endmodule
